// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the feature-map SRAM port arbiter.
package sram_port_arbiter_pkg;

  localparam int ID_W = 4;  // wide enough for up to 16 requesters
  typedef logic [ID_W-1:0] req_id_t;

  localparam req_id_t ID_LOAD = 4'd0;
  localparam req_id_t ID_SAVE = 4'd1;
  localparam req_id_t ID_HOST = 4'd2;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  localparam logic SRAM_DIS = 1'b0;
  localparam logic SRAM_EN  = 1'b1;
  localparam logic SRAM_RD  = 1'b0;
  localparam logic SRAM_WR  = 1'b1;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  function automatic req_id_t rr_next(input req_id_t last, input int off, input int n);
    return req_id_t'((int'(last) + off) % n);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after `last`.
module rr_pick
  import sram_port_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  req_id_t      last,
  input  logic [N-1:0] mask,
  output logic [N-1:0] win
);

  logic [N-1:0] elig;
  assign elig = req & mask;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win = '0;
    // Farthest candidate first, so the nearest eligible one after `last` overwrites.
    for (int off = N; off >= 1; off--) begin
      for (int i = 0; i < N; i++) begin
        if (elig[i] && rr_next(last, off, N) == req_id_t'(i)) begin
          win    = '0;
          win[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one feature-map SRAM port, with read-return tagging
// and an owner lock for atomic read-modify-write.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RD_LAT   = 2,
  parameter int LOCK_TMO = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                sram_en,
  output logic                sram_we,
  output logic [AW-1:0]       sram_addr,
  output logic [DW-1:0]       sram_din,
  input  logic [DW-1:0]       sram_dout,
  output logic                idle,
  output logic                lock_err
);

  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
  localparam logic [3:0]       TMO_LAST = 4'(LOCK_TMO - 1);

  arb_state_e       state;
  req_id_t          last, owner, win_id;
  logic [3:0]       tmo_cnt;
  logic [N_REQ-1:0] mask;
  rd_tag_t          pipe [RD_LAT];
  logic [RD_LAT-1:0] pipe_valid;
  logic             xfer, sel_we, sel_lock;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_din;

  assign mask = (state == LOCKED) ? (ONE << owner) : '1;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req),
    .last (last),
    .mask (mask),
    .win  (gnt)
  );

  assign xfer = |gnt;

  always_comb begin
    win_id   = '0;
    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_id   = req_id_t'(i);
        sel_we   = we[i];
        sel_lock = lock[i];
        sel_addr = addr[i*AW +: AW];
        sel_din  = wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    pipe_valid = '0;
    for (int k = 0; k < RD_LAT; k++) pipe_valid[k] = pipe[k].valid;
  end

  assign idle = ~|req & ~|pipe_valid & ~sram_en;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNLOCKED;
      owner     <= '0;
      last      <= req_id_t'(N_REQ - 1);
      tmo_cnt   <= '0;
      lock_err  <= 1'b0;
      sram_en   <= SRAM_DIS;
      sram_we   <= SRAM_RD;
      sram_addr <= '0;
      sram_din  <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      // NOTE: the tag pipe is control state, so it is reset; this drops reads in flight.
      for (int k = 0; k < RD_LAT; k++) pipe[k] <= '0;
    end else begin
      sram_en <= xfer ? SRAM_EN : SRAM_DIS;
      sram_we <= (xfer && sel_we) ? SRAM_WR : SRAM_RD;
      if (xfer) begin
        sram_addr <= sel_addr;
        sram_din  <= sel_din;
      end

      pipe[0] <= '{valid: xfer & ~sel_we, id: win_id};
      for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
      rvalid <= pipe[RD_LAT-1].valid ? (ONE << pipe[RD_LAT-1].id) : '0;
      if (pipe[RD_LAT-1].valid) rdata <= sram_dout;

      case (state)
        UNLOCKED: begin
          if (xfer) begin
            last <= win_id;
            if (sel_lock) begin
              state   <= LOCKED;
              owner   <= win_id;
              tmo_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          // An owner transfer beats a coincident timeout.
          if (xfer) begin
            last    <= win_id;
            tmo_cnt <= '0;
            if (!sel_lock) state <= UNLOCKED;
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= UNLOCKED;
            lock_err <= 1'b1;
            last     <= owner;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: vector table for reset/round-robin,
// hand sequences for lock, timeout, read-after-write, mid-read reset and idle.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk, rst;
  logic [N-1:0]    req, we, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            sram_en, sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_din, sram_dout;
  logic            idle, lock_err;

  int n_vec  = 0;
  int n_miss = 0;

  sram_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .RD_LAT(2), .LOCK_TMO(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout),
    .idle      (idle),
    .lock_err  (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model, one cycle read latency. Storage is kept XORed with addr^A5A5 so an
  // unwritten word reads back as addr ^ 16'hA5A5.
  bit [DW-1:0] mem [0:65535];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_din ^ sram_addr ^ 16'hA5A5;
      else         sram_dout      <= mem[sram_addr] ^ sram_addr ^ 16'hA5A5;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[id*AW +: AW]  = a;
    wdata[id*DW +: DW] = d;
  endtask

  typedef struct {
    logic [N-1:0]  req, we, lock;
    logic [N-1:0]  gnt;
    logic          en;
    logic [N-1:0]  rv;
    logic [DW-1:0] rd;
    logic          idle;
  } vec_t;

  vec_t tbl [7];

  initial begin
    // All-read round robin from reset; load=0x0010, save=0x0020, host=0x0030.
    tbl[0] = '{3'b111, 3'b000, 3'b000, 3'b001, 1'b0, 3'b000, 16'h0000, 1'b0};
    tbl[1] = '{3'b111, 3'b000, 3'b000, 3'b010, 1'b1, 3'b000, 16'h0000, 1'b0};
    tbl[2] = '{3'b111, 3'b000, 3'b000, 3'b100, 1'b1, 3'b000, 16'h0000, 1'b0};
    tbl[3] = '{3'b111, 3'b000, 3'b000, 3'b001, 1'b1, 3'b001, 16'hA5B5, 1'b0};
    tbl[4] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 3'b010, 16'hA585, 1'b0};
    tbl[5] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b100, 16'hA595, 1'b0};
    tbl[6] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b001, 16'hA5B5, 1'b1};

    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst sram_en", 32'(sram_en), 32'd0);
    check("rst sram_we", 32'(sram_we), 32'd0);
    check("rst sram_addr", 32'(sram_addr), 32'h0);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst rdata", 32'(rdata), 32'h0);
    check("rst lock_err", 32'(lock_err), 32'd0);
    check("rst idle", 32'(idle), 32'd1);
    tick();

    set_port(int'(ID_LOAD), 16'h0010, 16'h0);
    set_port(int'(ID_SAVE), 16'h0020, 16'h0);
    set_port(int'(ID_HOST), 16'h0030, 16'h0);
    for (int v = 0; v < 7; v++) begin
      req = tbl[v].req; we = tbl[v].we; lock = tbl[v].lock;
      #1;
      check($sformatf("rr[%0d] gnt", v), 32'(gnt), 32'(tbl[v].gnt));
      check($sformatf("rr[%0d] sram_en", v), 32'(sram_en), 32'(tbl[v].en));
      check($sformatf("rr[%0d] rvalid", v), 32'(rvalid), 32'(tbl[v].rv));
      check($sformatf("rr[%0d] rdata", v), 32'(rdata), 32'(tbl[v].rd));
      check($sformatf("rr[%0d] idle", v), 32'(idle), 32'(tbl[v].idle));
      tick();
    end

    // Read-modify-write by save at 0x0040 while load keeps requesting.
    set_port(int'(ID_SAVE), 16'h0040, 16'h1111);
    req = 3'b011; we = 3'b000; lock = 3'b010;
    #1; check("rmw lock read gnt", 32'(gnt), 32'b010);
    tick();
    req = 3'b001; lock = 3'b000;
    #1; check("rmw locked gnt c1", 32'(gnt), 32'b000);
    tick();
    #1; check("rmw locked gnt c2", 32'(gnt), 32'b000);
    check("rmw no rvalid yet", 32'(rvalid), 32'b000);
    tick();
    req = 3'b011; we = 3'b010; lock = 3'b000;
    #1; check("rmw save rvalid", 32'(rvalid), 32'b010);
    check("rmw save rdata", 32'(rdata), 32'hA5E5);
    check("rmw write gnt", 32'(gnt), 32'b010);
    tick();
    req = 3'b001; we = 3'b000;
    #1; check("rmw load after unlock", 32'(gnt), 32'b001);
    check("rmw sram_we", 32'(sram_we), 32'd1);
    check("rmw sram_addr", 32'(sram_addr), 32'h0040);
    check("rmw sram_din", 32'(sram_din), 32'h1111);
    check("rmw lock_err", 32'(lock_err), 32'd0);
    tick();
    req = '0;
    tick(); tick(); tick();

    // Lock timeout: save locks then goes quiet; host waits.
    set_port(int'(ID_SAVE), 16'h0050, 16'h0);
    req = 3'b110; we = 3'b000; lock = 3'b010;
    #1; check("tmo lock gnt", 32'(gnt), 32'b010);
    tick();
    req = 3'b100; lock = 3'b000;
    for (int k = 1; k <= 15; k++) begin
      #1;
      check($sformatf("tmo held gnt k=%0d", k), 32'(gnt), 32'b000);
      check($sformatf("tmo lock_err k=%0d", k), 32'(lock_err), 32'd0);
      tick();
    end
    #1; check("tmo host gnt", 32'(gnt), 32'b100);
    check("tmo lock_err set", 32'(lock_err), 32'd1);
    tick();
    req = '0;
    tick(); tick(); tick();

    // Read-after-write by host.
    check("lock_err sticky", 32'(lock_err), 32'd1);
    set_port(int'(ID_HOST), 16'h1234, 16'hBEEF);
    req = 3'b100; we = 3'b100;
    #1; check("raw write gnt", 32'(gnt), 32'b100);
    tick();
    we = 3'b000;
    #1; check("raw read gnt", 32'(gnt), 32'b100);
    check("raw write sram_we", 32'(sram_we), 32'd1);
    tick();
    req = '0;
    #1; check("raw read sram_we", 32'(sram_we), 32'd0);
    check("raw read sram_addr", 32'(sram_addr), 32'h1234);
    tick();
    #1; check("raw no early rvalid", 32'(rvalid), 32'b000);
    tick();
    #1; check("raw rvalid", 32'(rvalid), 32'b100);
    check("raw rdata", 32'(rdata), 32'hBEEF);
    tick();

    // Reset one cycle after a save read issues.
    set_port(int'(ID_SAVE), 16'h0070, 16'h0);
    req = 3'b010;
    #1; check("mrst read gnt", 32'(gnt), 32'b010);
    tick();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    #1; check("mrst lock_err cleared", 32'(lock_err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("mrst rvalid c%0d", k), 32'(rvalid), 32'b000);
      check($sformatf("mrst idle c%0d", k), 32'(idle), 32'd1);
      tick();
    end
    req = 3'b111;
    #1; check("mrst pointer reset gnt", 32'(gnt), 32'b001);
    tick();
    req = '0;
    tick(); tick(); tick();

    // Single write then idle.
    set_port(int'(ID_LOAD), 16'h0080, 16'h5555);
    req = 3'b001; we = 3'b001;
    #1; check("idle wr gnt", 32'(gnt), 32'b001);
    check("idle busy on req", 32'(idle), 32'd0);
    tick();
    req = '0; we = '0;
    #1; check("idle sram_en pulse", 32'(sram_en), 32'd1);
    check("idle sram_we pulse", 32'(sram_we), 32'd1);
    check("idle busy on en", 32'(idle), 32'd0);
    tick();
    #1; check("idle sram_en low", 32'(sram_en), 32'd0);
    check("idle sram_we low", 32'(sram_we), 32'd0);
    check("idle back", 32'(idle), 32'd1);
    check("idle addr held", 32'(sram_addr), 32'h0080);
    tick();
    #1; check("idle sram_en stays low", 32'(sram_en), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single-port feature-map SRAM between three requesters: the activation load path, the save/pool/ReLU write-back path, and the host/debug port. It does round-robin arbitration with one access issued per cycle, and tags read returns back to their issuer. It also supports a lock so that the save path's read-accumulate-write sequence on one address runs atomically. The block sits between the layer datapath units and the SRAM macro, and replaces the direct SRAM drive from each unit.

## Interface
Parameters:
- `N_REQ`, 3, number of requesters; id 0 = load, 1 = save, 2 = host.
- `AW`, 16, address width.
- `DW`, 16, data width.
- `RD_LAT`, 2, cycles from an SRAM read-enable cycle to the cycle the returned data is presented.
- `LOCK_TMO`, 15, idle cycles a lock owner may hold the port before forced release.

Ports:
- `clk`, in, 1, single clock, all logic on its rising edge.
- `rst`, in, 1, reset; synchronous, active-high.
- `req`, in, N_REQ, per-requester access request.
- `we`, in, N_REQ, per-requester write flag: 1 = write, 0 = read.
- `lock`, in, N_REQ, per-requester lock flag, sampled with the request.
- `addr`, in, N_REQ*AW, packed addresses; requester i owns `[i*AW +: AW]`.
- `wdata`, in, N_REQ*DW, packed write data, same packing as `addr`.
- `gnt`, out, N_REQ, combinational; one-hot or zero.
- `rvalid`, out, N_REQ, one-hot read-return strobe.
- `rdata`, out, DW, read return data, shared by all requesters.
- `sram_en`, out, 1, registered SRAM enable.
- `sram_we`, out, 1, registered SRAM write enable.
- `sram_addr`, out, AW, registered SRAM address.
- `sram_din`, out, DW, registered SRAM write data.
- `sram_dout`, in, DW, SRAM read data.
- `idle`, out, 1, no request pending and no read in flight.
- `lock_err`, out, 1, sticky; set on a lock timeout.

## Operation
- **Handshake.**
  - A requester holds `req`, `we`, `lock`, `addr` and `wdata` stable until it sees `gnt`.
  - The transfer happens on the edge where `req[i] & gnt[i]` are both high.
  - A requester may keep `req` high to issue back-to-back accesses.
- **Arbitration, state UNLOCKED.**
  - Round-robin pointer `last` holds the most recently granted id.
  - The search starts at `(last+1) mod N_REQ`, and the first requester found with `req` high wins.
  - `last` updates on every transfer.
- **Lock.**
  - A transfer with `lock=1` enters state LOCKED with `owner` set to that id.
  - In LOCKED, only `owner` can be granted; all other requesters see `gnt=0`.
  - A transfer by `owner` with `lock=0` returns the block to UNLOCKED. This is normally the write half of a read-modify-write.
  - A transfer by `owner` with `lock=1` stays LOCKED.
- **Lock timeout.**
  - `tmo_cnt` is 4 bits.
  - It clears on entering LOCKED and on every owner transfer.
  - It increments on every LOCKED cycle with no transfer.
  - When it reaches LOCK_TMO: go to UNLOCKED, set `lock_err`, and set `last=owner`.
- **Read return.**
  - A shift register RD_LAT deep, each stage holding `{valid, id}`, tracks reads in flight.
  - Reads complete in order. Writes enter the pipe with valid=0.
- **idle.** `idle = ~|req & ~|pipe_valid & ~sram_en`.

## Timing
- **Reset values:**
  - `sram_en=0`, `sram_we=0`, `sram_addr=0`, `sram_din=0`.
  - `rvalid=0`, `rdata=0`, `lock_err=0`.
  - Pipe cleared, state UNLOCKED, `last=N_REQ-1`, so id 0 wins first.
  - `idle=1` once `req=0`.
- **Reset mid-operation:**
  - Reads in flight are discarded and no `rvalid` is issued for them.
  - An active lock is dropped.
- **Issue:**
  - A transfer at edge e drives `sram_en=1`, `sram_we=we[i]`, `sram_addr`, `sram_din` during cycle e..e+1.
  - With no transfer, `sram_en=0` and `sram_we=0`; addr and din hold their last values.
- **Read return:**
  - The SRAM read is enabled in cycle c.
  - `sram_dout` is sampled at the end of cycle c+RD_LAT-1.
  - `rvalid[id]=1` and `rdata` are presented for the single cycle c+RD_LAT.
  - `rdata` holds its value otherwise.
- **Throughput:** one transfer per cycle. Read-after-write to the same address returns the new data, because issue is in order.
- **Simultaneous events:**
  - A lock-release transfer and another requester's `req` in the same cycle: the other requester becomes grantable the next cycle.
  - Timeout and an owner `req` in the same cycle: the owner transfer wins and `tmo_cnt` clears.
- **Same-cycle behaviour:** `gnt` depends only on state, `last` and `req` in the current cycle; it does not depend on `we`, `lock` or `addr`.

## Structure
- **Shared package:**
  - Requester id constants: `ID_LOAD=0`, `ID_SAVE=1`, `ID_HOST=2`.
  - State encoding: UNLOCKED, LOCKED.
  - SRAM enable/write encodings, reusing the existing enable/disable and read/write macros in `defines.v`.
- **Sub-module:** `rr_pick`, a combinational round-robin picker. Inputs are the request vector, `last` and a mask; output is a one-hot winner. In LOCKED the mask is the owner's one-hot.
- **Size:** roughly 180–250 lines of RTL total.

## Test plan
- **Reset and first grant.** `rst` high for 2 cycles, then `req=3'b111` with all reads.
  - Grants go 0, 1, 2, 0 on consecutive cycles, `sram_en=1` each cycle.
  - `rvalid` returns ids 0, 1, 2 starting 2 cycles after the first enable.
- **Read-modify-write.** Save path reads addr 0x0040 with `lock=1` while load holds `req` high.
  - Load gets `gnt=0` until save writes 0x0040 with `lock=0`.
  - Save's `rvalid` arrives before its write issues.
  - Load is granted the cycle after the write.
- **Lock timeout.** Save locks, then drops `req` for 15 cycles.
  - `lock_err=1` and the block returns to UNLOCKED.
  - The pending host `req` is granted the next cycle.
- **Read-after-write.** Host writes 0xBEEF to 0x1234 and reads 0x1234 back-to-back.
  - `rvalid[2]` fires with `rdata=0xBEEF`, 2 cycles after the read enable.
- **Reset mid-read.** `rst` asserted 1 cycle after a read is issued.
  - No `rvalid` follows, `idle=1`, and the pointer resets so id 0 wins next.
- **Idle behaviour.** Single write, then `req=0`.
  - `sram_en` is high for exactly 1 cycle, `idle` returns to 1 the cycle after, and `sram_we` returns to 0.
